// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store engine: access codes, FSM states
// and size/alignment helpers.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  // Loads and stores share the low two funct3 bits for width; unused codes act as word.
  function automatic size_t size_of(input logic [1:0] f);
    case (f)
      2'b00:   size_of = SZ_BYTE;
      2'b01:   size_of = SZ_HALF;
      default: size_of = SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: align_lo = lo;
      SZ_HALF: align_lo = {lo[1], 1'b0};
      default: align_lo = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = |lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
// Purely combinational so the forwarding path can reuse it.
module mem_access_unit_load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension according to funct3.
  always_comb begin
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  data = {24'h000000, byte_s};
      F3_LH:   data = {{16{half_s[15]}}, half_s};
      F3_LHU:  data = {16'h0000, half_s};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine driving a word-wide request/ready memory bus.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            mem_read,
  input  logic [2:0]            mem_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           store_data,
  output logic [31:0]           load_data,
  output logic                  load_valid,
  output logic                  busy,
  output logic                  mem_err,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state_r, next_state_s;
  logic              load_req_s, store_req_s, req_s, mis_s, wait_last_s;
  size_t             size_s;
  logic [1:0]        lo_s, lo_r;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s, fmt_s;
  logic              is_load_r;
  logic [2:0]        funct3_r;
  logic [WAIT_W-1:0] wait_cnt_r;

  // A simultaneous load and store performs the load and drops the store.
  assign load_req_s  = mem_read[3];
  assign store_req_s = mem_write[2] & ~mem_read[3];
  assign req_s       = load_req_s | store_req_s;
  assign size_s      = load_req_s ? size_of(mem_read[1:0]) : size_of(mem_write[1:0]);
  assign lo_s        = align_lo(size_s, address[1:0]);
  assign wait_last_s = (wait_cnt_r == WAIT_LAST);

`ifdef MISALIGN_TRAP_EN
  assign mis_s = req_s & is_misaligned(size_s, address[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  // Byte enables and lane-replicated write data for the request being captured.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = 32'h00000000;
    if (load_req_s) begin
      be_s    = 4'b1111;
      wdata_s = 32'h00000000;
    end else begin
      case (mem_write[1:0])
        ST_SB:   begin be_s = 4'b0001 << lo_s; wdata_s = {4{store_data[7:0]}}; end
        ST_SH:   begin be_s = lo_s[1] ? 4'b1100 : 4'b0011; wdata_s = {2{store_data[15:0]}}; end
        ST_SW:   begin be_s = 4'b1111; wdata_s = store_data; end
        default: begin be_s = 4'b1111; wdata_s = store_data; end
      endcase
    end
  end

  mem_access_unit_load_formatter u_fmt (
    .rdata   (mem_rdata),
    .funct3  (funct3_r),
    .addr_lo (lo_r),
    .data    (fmt_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (req_s) next_state_s = mis_s ? DONE : ACCESS;
        else       next_state_s = IDLE;
      end
      ACCESS: begin
        if (mem_ready || wait_last_s) next_state_s = DONE;
        else                          next_state_s = ACCESS;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Stall request: asserted from the moment a request is seen until DONE.
  always_comb begin
    busy = 1'b0;
    if (!reset) begin
      busy = 1'b0;
    end else begin
      case (state_r)
        IDLE:    busy = req_s;
        ACCESS:  busy = 1'b1;
        DONE:    busy = 1'b0;
        default: busy = 1'b0;
      endcase
    end
  end

  // Request capture, bus outputs, wait counter, load result and status pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      is_load_r  <= 1'b0;
      funct3_r   <= 3'b000;
      lo_r       <= 2'b00;
      wait_cnt_r <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h00000000;
      load_data  <= 32'h00000000;
      load_valid <= 1'b0;
      mem_err    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      mem_err    <= 1'b0;
      misaligned <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_s && mis_s) begin
            misaligned <= 1'b1;
          end else if (req_s) begin
            is_load_r  <= load_req_s;
            funct3_r   <= mem_read[2:0];
            lo_r       <= lo_s;
            wait_cnt_r <= '0;
            mem_req    <= 1'b1;
            mem_we     <= store_req_s;
            mem_addr   <= {address[ADDR_WIDTH-1:2], 2'b00};
            mem_be     <= be_s;
            mem_wdata  <= wdata_s;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (is_load_r) begin
              load_data  <= fmt_s;
              load_valid <= 1'b1;
            end
          end else if (wait_last_s) begin
            mem_req <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases with literal expectations
// plus randomized transactions checked every cycle against a transaction-level model.
module tb_mem_access_unit;

  localparam int TB_MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] address, store_data;
  logic [31:0] load_data;
  logic        load_valid, busy, mem_err, misaligned, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ready;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32), .MAX_WAIT(TB_MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .load_valid (load_valid),
    .busy       (busy),
    .mem_err    (mem_err),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, written by the stimulus side.
  logic        chk_en = 1'b0;
  logic        e_busy = 1'b0, e_req = 1'b0, e_lv = 1'b0, e_err = 1'b0, e_mis = 1'b0;
  logic        e_bus_chk = 1'b0, e_wd_chk = 1'b0, e_we = 1'b0;
  logic [31:0] e_ld = 32'h0, e_addr = 32'h0, e_wdata = 32'h0;
  logic [3:0]  e_be = 4'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Single per-cycle comparison against the model expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("load_valid", 32'(load_valid), 32'(e_lv));
      chk("mem_err", 32'(mem_err), 32'(e_err));
      chk("misaligned", 32'(misaligned), 32'(e_mis));
      chk("load_data", load_data, e_ld);
      if (e_bus_chk) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_wd_chk) chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  // Model: width code 0 = byte, 1 = half, 2/3 = word.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    if (f3[1:0] == 2'd0) begin
      sh = int'(a[1:0]) * 8;
      v = (rd >> sh) & 32'h000000FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
    end else if (f3[1:0] == 2'd1) begin
      sh = a[1] ? 16 : 0;
      v = (rd >> sh) & 32'h0000FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic rand_inputs();
    mem_read   = 4'($urandom);
    mem_write  = 3'($urandom);
    address    = $urandom;
    store_data = $urandom;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      rand_inputs();
      mem_read[3] = 1'b0;
      mem_write[2] = 1'b0;
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      e_busy = 1'b0; e_req = 1'b0; e_lv = 1'b0; e_err = 1'b0; e_mis = 1'b0;
      e_bus_chk = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_txn(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                         input logic [31:0] sd, input int w, input logic [31:0] rdat,
                         input logic pin_bus, input logic [31:0] p_addr, input logic [3:0] p_be,
                         input logic [31:0] p_wdata, input logic pin_ld, input logic [31:0] p_ld,
                         input int p_busy);
    logic is_ld, is_st, mis, tout;
    logic [1:0] sz;
    int n, busy_cnt;
    is_ld = rd[3];
    is_st = wr[2] && !rd[3];
    sz = is_ld ? rd[1:0] : wr[1:0];
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`endif
    tout = 1'b0;
    busy_cnt = 0;
    // Request cycle.
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; address = a; store_data = sd;
    mem_ready = 1'b0; mem_rdata = $urandom;
    e_busy = 1'b1; e_req = 1'b0; e_lv = 1'b0; e_err = 1'b0; e_mis = 1'b0; e_bus_chk = 1'b0;
    @(negedge clk);
    busy_cnt += int'(busy);
    if (!mis) begin
      tout = (w + 1 > TB_MAX_WAIT);
      n = tout ? TB_MAX_WAIT : w + 1;
      e_addr = a & 32'hFFFFFFFC;
      e_we = is_st;
      e_wd_chk = is_st;
      if (is_ld) begin
        e_be = 4'hF; e_wdata = 32'h0;
      end else if (sz == 2'd0) begin
        e_be = 4'(1 << a[1:0]); e_wdata = sd[7:0] * 32'h01010101;
      end else if (sz == 2'd1) begin
        e_be = a[1] ? 4'hC : 4'h3; e_wdata = sd[15:0] * 32'h00010001;
      end else begin
        e_be = 4'hF; e_wdata = sd;
      end
      for (int j = 1; j <= n; j++) begin
        @(posedge clk); #1;
        rand_inputs();
        mem_ready = (!tout && j == n);
        mem_rdata = mem_ready ? rdat : $urandom;
        e_busy = 1'b1; e_req = 1'b1; e_bus_chk = 1'b1;
        @(negedge clk);
        busy_cnt += int'(busy);
        if (pin_bus && j == 1) begin
          chk("pin_addr", mem_addr, p_addr);
          chk("pin_be", 32'(mem_be), 32'(p_be));
          if (is_st) chk("pin_wdata", mem_wdata, p_wdata);
        end
      end
    end
    // Completion cycle: enables driven here must be ignored.
    @(posedge clk); #1;
    rand_inputs();
    mem_ready = 1'b0; mem_rdata = $urandom;
    e_busy = 1'b0; e_req = 1'b0; e_bus_chk = 1'b0;
    e_lv = is_ld && !tout && !mis;
    e_err = tout;
    e_mis = mis;
    if (e_lv) e_ld = model_load(rd[2:0], a, rdat);
    @(negedge clk);
    busy_cnt += int'(busy);
    if (pin_ld) chk("pin_load_data", load_data, p_ld);
    if (p_busy >= 0) chk("pin_busy_cycles", 32'(busy_cnt), 32'(p_busy));
  endtask

  task automatic expect_zero_outputs();
    e_busy = 1'b0; e_req = 1'b0; e_lv = 1'b0; e_err = 1'b0; e_mis = 1'b0;
    e_ld = 32'h0; e_bus_chk = 1'b1; e_wd_chk = 1'b1;
    e_addr = 32'h0; e_be = 4'h0; e_we = 1'b0; e_wdata = 32'h0;
  endtask

  initial begin
    reset = 1'b0;
    mem_read = 4'h0; mem_write = 3'h0; address = 32'h0; store_data = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;
    @(posedge clk); #1;
    expect_zero_outputs();
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    idle(1);

    // Directed cases with literal expectations.
    run_txn(4'h0, 3'b110, 32'h104, 32'hDEADBEEF, 0, 32'h0,
            1'b1, 32'h104, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0, 2);
    run_txn(4'h0, 3'b100, 32'h203, 32'h000000A5, 0, 32'h0,
            1'b1, 32'h200, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0, 2);
    run_txn(4'b1000, 3'b000, 32'h302, 32'h0, 0, 32'h12F03456,
            1'b1, 32'h300, 4'b1111, 32'h0, 1'b1, 32'hFFFFFFF0, 2);
    run_txn(4'b1100, 3'b000, 32'h302, 32'h0, 0, 32'h12F03456,
            1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h000000F0, 2);
    run_txn(4'b1001, 3'b000, 32'h402, 32'h0, 3, 32'h80017FFF,
            1'b1, 32'h400, 4'b1111, 32'h0, 1'b1, 32'hFFFF8001, 5);
    run_txn(4'b1010, 3'b000, 32'h010, 32'h0, 10, 32'h0,
            1'b1, 32'h010, 4'b1111, 32'h0, 1'b1, 32'hFFFF8001, 5);
    // Load and store enabled together: only the load happens.
    run_txn(4'b1010, 3'b110, 32'h020, 32'h11111111, 1, 32'h0BADCAFE,
            1'b1, 32'h020, 4'b1111, 32'h0, 1'b1, 32'h0BADCAFE, 3);
`ifdef MISALIGN_TRAP_EN
    run_txn(4'b1010, 3'b000, 32'h501, 32'h0, 0, 32'hCAFEF00D,
            1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0BADCAFE, 1);
`else
    run_txn(4'b1010, 3'b000, 32'h501, 32'h0, 0, 32'hCAFEF00D,
            1'b1, 32'h500, 4'b1111, 32'h0, 1'b1, 32'hCAFEF00D, 2);
`endif
    idle(2);

    // Reset asserted in the middle of an access.
    @(posedge clk); #1;
    mem_read = 4'b1010; mem_write = 3'b000; address = 32'h600; mem_ready = 1'b0;
    e_busy = 1'b1; e_req = 1'b0; e_lv = 1'b0; e_err = 1'b0; e_mis = 1'b0; e_bus_chk = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      rand_inputs();
      mem_ready = 1'b0;
      e_busy = 1'b1; e_req = 1'b1; e_bus_chk = 1'b1; e_wd_chk = 1'b0;
      e_addr = 32'h600; e_be = 4'hF; e_we = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    e_busy = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    expect_zero_outputs();
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    mem_read = 4'h0; mem_write = 3'h0;
    @(negedge clk);

    // Randomized transactions with random idle gaps.
    for (int t = 0; t < 200; t++) begin
      logic [3:0] rd;
      logic [2:0] wr;
      rd = 4'($urandom);
      wr = 3'($urandom);
      if (!rd[3] && !wr[2]) rd[3] = 1'b1;
      run_txn(rd, wr, $urandom, $urandom, int'($urandom_range(0, 5)), $urandom,
              1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, -1);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
